// File: rtl/ixc_assign_sched_10.sv
// Round-robin scheduler that shares one W-bit assign channel between NREQ
// requesters, registering the granted requester's words onto L.
module ixc_assign_sched_10 #(
    parameter int NREQ     = 4,
    parameter int W        = 10,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_rdy,
    output logic [W-1:0]      L,
    output logic              l_vld,
    input  logic              l_rdy,
    output logic [1:0]        grant_id,
    output logic              busy
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [W-1:0] l_q, l_d;
    logic        l_vld_q, l_vld_d;

    logic        out_free;
    logic        accept;
    logic        release_now;
    logic [2:0]  pick;

    // First requesting index scanning ptr, ptr+1, ... modulo NREQ; bit 2 flags a hit.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] vld, input logic [1:0] ptr);
        logic [2:0] res;
        int         idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (vld[idx]) res = {1'b1, 2'(idx)};
        end
        return res;
    endfunction

    assign pick        = rr_pick(req_vld, rr_ptr_q);
    assign out_free    = !l_vld_q || l_rdy;
    assign accept      = (state_q == XFER) && req_vld[grant_id_q] && out_free;
    assign release_now = accept &&
                         (req_last[grant_id_q] || ((hold_cnt_q + 4'd1) == 4'(HOLD_MAX)));

    // req_rdy depends only on registered state and l_rdy, never on req_vld/req_data.
    always_comb begin
        req_rdy = '0;
        if (state_q == XFER) req_rdy[grant_id_q] = out_free;
    end

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        l_d        = l_q;
        l_vld_d    = l_vld_q;

        if (l_vld_q && l_rdy) l_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    grant_id_d = pick[1:0];
                    hold_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    l_d        = req_data[int'(grant_id_q)*W +: W];
                    l_vld_d    = 1'b1;
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
                if (release_now) begin
                    rr_ptr_d = (int'(grant_id_q) == NREQ - 1) ? 2'd0 : grant_id_q + 2'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            l_q        <= '0;
            l_vld_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            l_q        <= l_d;
            l_vld_q    <= l_vld_d;
        end
    end

    assign L        = l_q;
    assign l_vld    = l_vld_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == XFER);

endmodule
